cpu64_l2_dir_probe_ctrl: RTL and testbench
==========================================

// Module: cpu64_l2_dir_probe_ctrl
// PURPOSE
//  Transaction sequencer for cpu64_l2_directory. Takes one L1 acquire (shared/unique) at a time.
//  Reads the directory entry and probes conflicting cores (toB or toN), then collects their acks.
//  Writes the updated entry back and issues a grant. Sits between the L2 request arbiter and
//  cpu64_l2_directory.
// PARAMETERS
//  SETS   256  directory sets; SW = $clog2(SETS)
//  WAYS   16   ways per set; WW = $clog2(WAYS)
//  CORES  4    L1 clients; CW = max(1,$clog2(CORES))
// PORTS
//  clk                  in   1            clock
//  rst_n                in   1            asynchronous, active-low reset
//  req_valid_i          in   1            acquire request valid
//  req_ready_o          out  1            controller idle, accepts request
//  req_set_i/req_way_i  in   SW/WW        target line location (hit way already resolved)
//  req_core_i           in   CW           requesting core
//  req_unique_i         in   1            1 = acquire write permission, 0 = read permission
//  dir_rd_set_o         out  SW           directory read set (combinational read)
//  dir_rd_valid_i       in   WAYS         directory valid per way
//  dir_rd_sharers_i     in   WAYS*CORES   sharer vectors
//  dir_rd_owner_valid_i in   WAYS         owner valid per way
//  dir_rd_owner_id_i    in   WAYS*CW      owner ids
//  dir_rd_dirty_i       in   WAYS         dirty per way
//  dir_we_o             out  1            directory write strobe
//  dir_wr_set_o/way_o   out  SW/WW        write location
//  dir_wr_valid_o, dir_wr_sharers_o[CORES], dir_wr_owner_valid_o, dir_wr_owner_id_o[CW], dir_wr_dirty_o  out  entry
//  probe_valid_o        out  1            probe broadcast valid
//  probe_ready_i        in   1            probe network accepts
//  probe_mask_o         out  CORES        cores to probe
//  probe_inval_o        out  1            1 = toN (invalidate), 0 = toB (downgrade)
//  ack_valid_i          in   1            probe ack, max one per cycle
//  ack_core_i           in   CW           acking core
//  ack_dirty_i          in   1            ack carries dirty data
//  grant_valid_o        out  1            grant valid
//  grant_ready_i        in   1            grant accepted
//  grant_core_o         out  CW           grantee
//  grant_unique_o       out  1            resulting permission is unique/owner
//  grant_dirty_o        out  1            probed/owned data dirty, L2 data path must absorb it
//  busy_o               out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE and all outputs 0. pending mask, latched entry and dirty_seen are cleared.
//    req_ready_o=1 from the first clock after reset deassertion. Reset mid-transaction aborts it
//    immediately; no directory write occurs.
//  FSM IDLE->LOOKUP->(PROBE->WAIT_ACK)->UPDATE->GRANT->IDLE.
//  IDLE: req_ready_o=1. On req_valid_i&req_ready_o, latch set/way/core/unique -> LOOKUP.
//  LOOKUP (1 cycle): dir_rd_set_o=latched set. Latch the entry of the latched way.
//    own = owner_valid ? onehot(owner_id) : 0; self = onehot(req_core).
//    entry invalid -> mask=0.
//    unique -> mask=(sharers|own)&~self.
//    shared -> mask=own&~self.
//    mask==0 -> UPDATE; else pending=mask -> PROBE.
//  PROBE: probe_valid_o=1, probe_mask_o=mask, probe_inval_o=unique; stable until probe_ready_i.
//    Handshake cycle -> WAIT_ACK. Acks arriving in PROBE are dropped (protocol forbids them).
//  WAIT_ACK: ack_valid_i with pending[ack_core_i]=1 clears that bit and ORs ack_dirty_i into dirty_seen.
//    Acks for non-pending cores, or in any other state, are ignored.
//    Move to UPDATE on the cycle after pending reaches 0.
//  UPDATE (1 cycle): dir_we_o=1 at latched set/way, valid=1. d = old_dirty|dirty_seen.
//    unique: owner_valid=1, owner_id=req_core, sharers=0, dirty=d.
//    shared, requester already owner: entry rewritten unchanged; grant_unique=1.
//    shared otherwise: owner_valid=0, owner_id=0, sharers=(old_sharers|own|self), dirty=0.
//  GRANT: grant_valid_o=1. grant_core/unique hold until grant_ready_i. grant_dirty_o=d.
//    Handshake -> IDLE; req_ready_o rises the following cycle.
//  Latency: no-probe request accepted at edge N gives dir_we_o in cycle N+2 and grant_valid_o
//    from N+3.
//  Probe path adds 1 cycle plus probe-ready wait plus ack wait plus 1 cycle.
//  Written entries always satisfy: owner_valid -> sharers=0; dirty -> owner_valid.
// TESTING
//  1 Invalid entry; unique req core1 set10 way5 -> no probe.
//    Write v=1 ov=1 oid=1 s=0000 d=0; grant 3 cycles after accept, unique=1.
//  2 Entry s=1010; unique req core1 -> probe mask=1000 inval=1.
//    Ack core3 -> write ov=1 oid=1 s=0000; grant unique.
//  3 Entry ov=1 oid=2 d=1; shared req core0 -> probe mask=0100 inval=0.
//    Ack core2 dirty=1 -> write ov=0 s=0101 d=0; grant_dirty=1 unique=0.
//  4 Entry s=1110; unique req core0 with probe_ready low 5 cycles -> probe outputs stable.
//    Stray ack core0 ignored; UPDATE only after acks 1,2,3.
//  5 grant_ready low 4 cycles -> grant outputs stable, req_ready_o=0, new req not accepted.
//  6 rst_n low during WAIT_ACK -> all outputs 0 at once, no dir write.
//    Next request completes normally.

Source files
------------

// File: rtl/cpu64_l2_dir_probe_ctrl.sv
`default_nettype none
// =============================================================================
// cpu64_l2_dir_probe_ctrl : one-at-a-time L1 acquire sequencer for the L2 directory
// Revision 1.0
// =============================================================================

module cpu64_l2_dir_probe_ctrl #(
  parameter int SETS  = 256,
  parameter int WAYS  = 16,
  parameter int CORES = 4,
  localparam int SW = $clog2(SETS),
  localparam int WW = $clog2(WAYS),
  localparam int CW = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SW-1:0]         req_set_i,
  input  logic [WW-1:0]         req_way_i,
  input  logic [CW-1:0]         req_core_i,
  input  logic                  req_unique_i,
  output logic [SW-1:0]         dir_rd_set_o,
  input  logic [WAYS-1:0]       dir_rd_valid_i,
  input  logic [WAYS*CORES-1:0] dir_rd_sharers_i,
  input  logic [WAYS-1:0]       dir_rd_owner_valid_i,
  input  logic [WAYS*CW-1:0]    dir_rd_owner_id_i,
  input  logic [WAYS-1:0]       dir_rd_dirty_i,
  output logic                  dir_we_o,
  output logic [SW-1:0]         dir_wr_set_o,
  output logic [WW-1:0]         dir_wr_way_o,
  output logic                  dir_wr_valid_o,
  output logic [CORES-1:0]      dir_wr_sharers_o,
  output logic                  dir_wr_owner_valid_o,
  output logic [CW-1:0]         dir_wr_owner_id_o,
  output logic                  dir_wr_dirty_o,
  output logic                  probe_valid_o,
  input  logic                  probe_ready_i,
  output logic [CORES-1:0]      probe_mask_o,
  output logic                  probe_inval_o,
  input  logic                  ack_valid_i,
  input  logic [CW-1:0]         ack_core_i,
  input  logic                  ack_dirty_i,
  output logic                  grant_valid_o,
  input  logic                  grant_ready_i,
  output logic [CW-1:0]         grant_core_o,
  output logic                  grant_unique_o,
  output logic                  grant_dirty_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    PROBE    = 3'd2,
    WAIT_ACK = 3'd3,
    UPDATE   = 3'd4,
    GRANT    = 3'd5
  } state_e;

  function automatic logic [CORES-1:0] onehot(input logic [CW-1:0] id);
    logic [CORES-1:0] oh;
    for (int c = 0; c < CORES; c++) oh[c] = (id == CW'(c));
    return oh;
  endfunction

  state_e           state_q, state_d;
  logic             init_q, init_d;
  logic [SW-1:0]    set_q, set_d;
  logic [WW-1:0]    way_q, way_d;
  logic [CW-1:0]    core_q, core_d;
  logic             unique_q, unique_d;
  logic [CORES-1:0] ent_sharers_q, ent_sharers_d;
  logic             ent_ov_q, ent_ov_d;
  logic [CW-1:0]    ent_oid_q, ent_oid_d;
  logic             ent_dirty_q, ent_dirty_d;
  logic [CORES-1:0] mask_q, mask_d;
  logic [CORES-1:0] pending_q, pending_d;
  logic             dirty_seen_q, dirty_seen_d;

  logic [CORES-1:0] rd_sharers_w [WAYS];
  logic [CW-1:0]    rd_oid_w     [WAYS];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign rd_sharers_w[w] = dir_rd_sharers_i[w*CORES +: CORES];
    assign rd_oid_w[w]     = dir_rd_owner_id_i[w*CW +: CW];
  end

  // An invalid entry is treated as all-zero so stale fields never leak into probes or writes.
  logic             lk_valid, lk_ov, lk_dirty;
  logic [CORES-1:0] lk_sharers, lk_own, lk_mask, self_oh, own_oh, ack_oh;
  logic [CW-1:0]    lk_oid;
  logic             self_owner, merged_dirty;

  assign lk_valid     = dir_rd_valid_i[way_q];
  assign lk_sharers   = lk_valid ? rd_sharers_w[way_q] : '0;
  assign lk_ov        = lk_valid & dir_rd_owner_valid_i[way_q];
  assign lk_oid       = lk_valid ? rd_oid_w[way_q] : '0;
  assign lk_dirty     = lk_valid & dir_rd_dirty_i[way_q];
  assign lk_own       = lk_ov ? onehot(lk_oid) : '0;
  assign self_oh      = onehot(core_q);
  assign lk_mask      = unique_q ? ((lk_sharers | lk_own) & ~self_oh) : (lk_own & ~self_oh);
  assign own_oh       = ent_ov_q ? onehot(ent_oid_q) : '0;
  assign ack_oh       = onehot(ack_core_i);
  assign self_owner   = ent_ov_q && (ent_oid_q == core_q);
  assign merged_dirty = ent_dirty_q | dirty_seen_q;
  assign busy_o       = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    init_d        = 1'b1;
    set_d         = set_q;
    way_d         = way_q;
    core_d        = core_q;
    unique_d      = unique_q;
    ent_sharers_d = ent_sharers_q;
    ent_ov_d      = ent_ov_q;
    ent_oid_d     = ent_oid_q;
    ent_dirty_d   = ent_dirty_q;
    mask_d        = mask_q;
    pending_d     = pending_q;
    dirty_seen_d  = dirty_seen_q;

    req_ready_o          = 1'b0;
    dir_rd_set_o         = '0;
    dir_we_o             = 1'b0;
    dir_wr_set_o         = '0;
    dir_wr_way_o         = '0;
    dir_wr_valid_o       = 1'b0;
    dir_wr_sharers_o     = '0;
    dir_wr_owner_valid_o = 1'b0;
    dir_wr_owner_id_o    = '0;
    dir_wr_dirty_o       = 1'b0;
    probe_valid_o        = 1'b0;
    probe_mask_o         = '0;
    probe_inval_o        = 1'b0;
    grant_valid_o        = 1'b0;
    grant_core_o         = '0;
    grant_unique_o       = 1'b0;
    grant_dirty_o        = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = init_q;
        if (req_valid_i && init_q) begin
          set_d        = req_set_i;
          way_d        = req_way_i;
          core_d       = req_core_i;
          unique_d     = req_unique_i;
          dirty_seen_d = 1'b0;
          state_d      = LOOKUP;
        end
      end
      LOOKUP: begin
        dir_rd_set_o  = set_q;
        ent_sharers_d = lk_sharers;
        ent_ov_d      = lk_ov;
        ent_oid_d     = lk_oid;
        ent_dirty_d   = lk_dirty;
        mask_d        = lk_mask;
        pending_d     = lk_mask;
        state_d       = (lk_mask == '0) ? UPDATE : PROBE;
      end
      PROBE: begin
        probe_valid_o = 1'b1;
        probe_mask_o  = mask_q;
        probe_inval_o = unique_q;
        if (probe_ready_i) state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (pending_q == '0) begin
          state_d = UPDATE;
        end else if (ack_valid_i && |(pending_q & ack_oh)) begin
          pending_d    = pending_q & ~ack_oh;
          dirty_seen_d = dirty_seen_q | ack_dirty_i;
        end
      end
      UPDATE: begin
        dir_we_o       = 1'b1;
        dir_wr_set_o   = set_q;
        dir_wr_way_o   = way_q;
        dir_wr_valid_o = 1'b1;
        if (unique_q) begin
          dir_wr_owner_valid_o = 1'b1;
          dir_wr_owner_id_o    = core_q;
          dir_wr_dirty_o       = merged_dirty;
        end else if (self_owner) begin
          dir_wr_sharers_o     = ent_sharers_q;
          dir_wr_owner_valid_o = 1'b1;
          dir_wr_owner_id_o    = ent_oid_q;
          dir_wr_dirty_o       = ent_dirty_q;
        end else begin
          // Former owner is demoted to sharer; its dirty data goes out with the grant.
          dir_wr_sharers_o = ent_sharers_q | own_oh | self_oh;
        end
        state_d = GRANT;
      end
      GRANT: begin
        grant_valid_o  = 1'b1;
        grant_core_o   = core_q;
        grant_unique_o = unique_q | self_owner;
        grant_dirty_o  = merged_dirty;
        if (grant_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      init_q        <= 1'b0;
      set_q         <= '0;
      way_q         <= '0;
      core_q        <= '0;
      unique_q      <= 1'b0;
      ent_sharers_q <= '0;
      ent_ov_q      <= 1'b0;
      ent_oid_q     <= '0;
      ent_dirty_q   <= 1'b0;
      mask_q        <= '0;
      pending_q     <= '0;
      dirty_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_q        <= init_d;
      set_q         <= set_d;
      way_q         <= way_d;
      core_q        <= core_d;
      unique_q      <= unique_d;
      ent_sharers_q <= ent_sharers_d;
      ent_ov_q      <= ent_ov_d;
      ent_oid_q     <= ent_oid_d;
      ent_dirty_q   <= ent_dirty_d;
      mask_q        <= mask_d;
      pending_q     <= pending_d;
      dirty_seen_q  <= dirty_seen_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu64_l2_dir_probe_ctrl.sv
`default_nettype none
// =============================================================================
// tb_cpu64_l2_dir_probe_ctrl : directed table plus randomized transactions vs a reference model
// Revision 1.0
// =============================================================================

module tb_cpu64_l2_dir_probe_ctrl;
  localparam int SETS = 256, WAYS = 16, CORES = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready_o;
  logic [7:0]  req_set = '0;
  logic [3:0]  req_way = '0;
  logic [1:0]  req_core = '0;
  logic        req_unique = 1'b0;
  logic [7:0]  dir_rd_set_o;
  logic [15:0] dir_rd_valid = '0, dir_rd_ov = '0, dir_rd_dirty = '0;
  logic [63:0] dir_rd_sharers = '0;
  logic [31:0] dir_rd_oid = '0;
  logic        dir_we_o, dir_wr_valid_o, dir_wr_owner_valid_o, dir_wr_dirty_o;
  logic [7:0]  dir_wr_set_o;
  logic [3:0]  dir_wr_way_o, dir_wr_sharers_o, probe_mask_o;
  logic [1:0]  dir_wr_owner_id_o, grant_core_o;
  logic        probe_valid_o, probe_inval_o, probe_ready = 1'b0;
  logic        ack_valid = 1'b0, ack_dirty = 1'b0;
  logic [1:0]  ack_core = '0;
  logic        grant_valid_o, grant_ready = 1'b0, grant_unique_o, grant_dirty_o, busy_o;

  cpu64_l2_dir_probe_ctrl #(.SETS(SETS), .WAYS(WAYS), .CORES(CORES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_set_i(req_set), .req_way_i(req_way),
    .req_core_i(req_core), .req_unique_i(req_unique),
    .dir_rd_set_o(dir_rd_set_o), .dir_rd_valid_i(dir_rd_valid), .dir_rd_sharers_i(dir_rd_sharers),
    .dir_rd_owner_valid_i(dir_rd_ov), .dir_rd_owner_id_i(dir_rd_oid), .dir_rd_dirty_i(dir_rd_dirty),
    .dir_we_o(dir_we_o), .dir_wr_set_o(dir_wr_set_o), .dir_wr_way_o(dir_wr_way_o),
    .dir_wr_valid_o(dir_wr_valid_o), .dir_wr_sharers_o(dir_wr_sharers_o),
    .dir_wr_owner_valid_o(dir_wr_owner_valid_o), .dir_wr_owner_id_o(dir_wr_owner_id_o),
    .dir_wr_dirty_o(dir_wr_dirty_o),
    .probe_valid_o(probe_valid_o), .probe_ready_i(probe_ready), .probe_mask_o(probe_mask_o),
    .probe_inval_o(probe_inval_o),
    .ack_valid_i(ack_valid), .ack_core_i(ack_core), .ack_dirty_i(ack_dirty),
    .grant_valid_o(grant_valid_o), .grant_ready_i(grant_ready), .grant_core_o(grant_core_o),
    .grant_unique_o(grant_unique_o), .grant_dirty_o(grant_dirty_o), .busy_o(busy_o)
  );

  logic [63:0] all_outs;
  assign all_outs = 64'({req_ready_o, dir_rd_set_o, dir_we_o, dir_wr_set_o, dir_wr_way_o,
                         dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o, dir_wr_owner_id_o,
                         dir_wr_dirty_o, probe_valid_o, probe_mask_o, probe_inval_o, grant_valid_o,
                         grant_core_o, grant_unique_o, grant_dirty_o, busy_o});

  typedef struct packed {
    logic       v;
    logic [3:0] s;
    logic       ov;
    logic [1:0] oid;
    logic       d;
  } entry_t;

  typedef struct {
    entry_t     ent;
    logic [7:0] set;
    logic [3:0] way;
    logic [1:0] core;
    logic       uniq;
    logic [3:0] adirty;
    int         rdly;
    int         gdly;
    bit         stray;
    bit         poke;
    logic [3:0] x_mask;
    entry_t     x_wr;
    logic       x_gu;
    logic       x_gd;
  } vec_t;

  typedef struct packed {
    logic [1:0] core;
    logic       dirty;
    logic       counted;
  } ack_t;

  int n_checks = 0, n_fail = 0, we_total = 0;

  always @(negedge clk) if (dir_we_o) we_total++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic entry_t mk(input logic v, input logic [3:0] s, input logic ov,
                                input logic [1:0] oid, input logic d);
    entry_t e;
    e.v = v; e.s = s; e.ov = ov; e.oid = oid; e.d = d;
    return e;
  endfunction

  // Reference: who holds a copy, who must be probed, and what the line becomes afterwards.
  function automatic void model(input entry_t e, input logic [1:0] core, input logic uniq,
                                input logic [3:0] adirty, output logic [3:0] mask,
                                output entry_t wr, output logic gu, output logic gd);
    logic holds, owns, any_d, old_d;
    logic [3:0] keep;
    mask = '0; keep = '0; any_d = 1'b0;
    old_d = e.v && e.d;
    for (int c = 0; c < 4; c++) begin
      owns  = e.v && e.ov && (e.oid == 2'(c));
      holds = owns || (e.v && e.s[c]);
      if (c != int'(core) && (uniq ? holds : owns)) mask[c] = 1'b1;
      if (holds || c == int'(core)) keep[c] = 1'b1;
      if (mask[c] && adirty[c]) any_d = 1'b1;
    end
    if (uniq) begin
      wr = mk(1'b1, 4'b0000, 1'b1, core, old_d | any_d); gu = 1'b1; gd = old_d | any_d;
    end else if (e.v && e.ov && e.oid == core) begin
      wr = e; gu = 1'b1; gd = old_d;
    end else begin
      wr = mk(1'b1, keep, 1'b0, 2'd0, 1'b0); gu = 1'b0; gd = old_d | any_d;
    end
  endfunction

  // Observations of the last transaction
  bit         o_probe_seen, o_unstable, o_g_seen, o_gunstable, o_timeout, o_early;
  logic [3:0] o_mask;
  logic       o_inval, o_gu, o_gd;
  int         o_probe_t, o_we_cnt, o_we_t, o_g_t;
  entry_t     o_wr;
  logic [7:0] o_wr_set;
  logic [3:0] o_wr_way;
  logic [1:0] o_gcore;

  task automatic present_dir(input entry_t e, input logic [3:0] way);
    for (int w = 0; w < WAYS; w++) begin
      dir_rd_valid[w]        = 1'($urandom_range(0, 1));
      dir_rd_sharers[w*4 +: 4] = 4'($urandom_range(0, 15));
      dir_rd_ov[w]           = 1'($urandom_range(0, 1));
      dir_rd_oid[w*2 +: 2]   = 2'($urandom_range(0, 3));
      dir_rd_dirty[w]        = 1'($urandom_range(0, 1));
    end
    dir_rd_valid[way]               = e.v;
    dir_rd_sharers[int'(way)*4 +: 4] = e.s;
    dir_rd_ov[way]                  = e.ov;
    dir_rd_oid[int'(way)*2 +: 2]    = e.oid;
    dir_rd_dirty[way]               = e.d;
  endtask

  task automatic do_txn(input entry_t ent, input logic [7:0] set, input logic [3:0] way,
                        input logic [1:0] core, input logic uniq, input logic [3:0] adirty,
                        input int rdly, input int gdly, input bit stray, input bit poke);
    int t, guard, pcyc, gcyc, need, delivered;
    bit p_hs, g_hs, done, ack_real;
    ack_t aq[$];
    ack_t a;
    o_probe_seen = 0; o_unstable = 0; o_g_seen = 0; o_gunstable = 0; o_timeout = 0; o_early = 0;
    o_mask = '0; o_inval = 0; o_gu = 0; o_gd = 0; o_gcore = '0;
    o_probe_t = -1; o_we_cnt = 0; o_we_t = -1; o_g_t = -1;
    o_wr = '0; o_wr_set = '0; o_wr_way = '0;
    pcyc = 0; gcyc = 0; need = 0; delivered = 0; p_hs = 0; g_hs = 0; done = 0; ack_real = 0;
    present_dir(ent, way);
    guard = 0;
    while (!req_ready_o && guard < 20) begin @(negedge clk); guard++; end
    if (!req_ready_o) o_timeout = 1;
    req_valid = 1'b1; req_set = set; req_way = way; req_core = core; req_unique = uniq;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    check("lookup_rd_set", 64'(dir_rd_set_o), 64'(set));
    check("lookup_busy", 64'(busy_o), 64'd1);
    while (!done && t < 300) begin
      if (ack_real) delivered++;
      ack_real = 0; ack_valid = 1'b0;
      if (g_hs) begin
        check("req_ready_after_grant", 64'(req_ready_o), 64'd1);
        check("grant_drop", 64'(grant_valid_o), 64'd0);
        req_valid = 1'b0; grant_ready = 1'b0; done = 1;
      end else begin
        if (dir_we_o) begin
          o_we_cnt++; o_we_t = t;
          o_wr = {dir_wr_valid_o, dir_wr_sharers_o, dir_wr_owner_valid_o, dir_wr_owner_id_o,
                  dir_wr_dirty_o};
          o_wr_set = dir_wr_set_o; o_wr_way = dir_wr_way_o;
          if (delivered != need) o_early = 1;
        end
        if (probe_valid_o) begin
          if (!o_probe_seen) begin
            o_probe_seen = 1; o_mask = probe_mask_o; o_inval = probe_inval_o; o_probe_t = t;
          end else if (probe_mask_o !== o_mask || probe_inval_o !== o_inval) o_unstable = 1;
          pcyc++;
          probe_ready = (pcyc > rdly);
          if (probe_ready) begin
            p_hs = 1;
            if (stray) aq.push_back({core, 1'b0, 1'b0});
            for (int c = 0; c < 4; c++)
              if (o_mask[c]) begin aq.push_back({2'(c), adirty[c], 1'b1}); need++; end
          end
        end else begin
          probe_ready = 1'b0;
          if (p_hs && aq.size() > 0) begin
            a = aq.pop_front();
            ack_valid = 1'b1; ack_core = a.core; ack_dirty = a.dirty; ack_real = a.counted;
          end
        end
        if (grant_valid_o) begin
          if (!o_g_seen) begin
            o_g_seen = 1; o_g_t = t; o_gcore = grant_core_o; o_gu = grant_unique_o; o_gd = grant_dirty_o;
          end else if (grant_core_o !== o_gcore || grant_unique_o !== o_gu || grant_dirty_o !== o_gd)
            o_gunstable = 1;
          gcyc++;
          grant_ready = (gcyc > gdly);
          if (grant_ready) g_hs = 1;
          else begin
            check("req_ready_low_in_grant", 64'(req_ready_o), 64'd0);
            if (poke) begin req_valid = 1'b1; req_core = ~core; req_unique = ~uniq; end
          end
        end
      end
      if (!done) begin @(negedge clk); t++; end
    end
    if (!done) o_timeout = 1;
    ack_valid = 1'b0; probe_ready = 1'b0; grant_ready = 1'b0; req_valid = 1'b0;
    if (poke) begin
      @(negedge clk);
      check("no_accept_during_grant", 64'(busy_o), 64'd0);
    end
  endtask

  task automatic check_txn(input string tag, input logic [7:0] set, input logic [3:0] way,
                           input logic [1:0] core, input logic uniq, input logic [3:0] xm,
                           input entry_t xw, input logic xgu, input logic xgd);
    check({tag, "_timeout"}, 64'(o_timeout), 64'd0);
    check({tag, "_probe_mask"}, 64'(o_probe_seen ? o_mask : 4'b0000), 64'(xm));
    if (xm != 4'b0000) begin
      check({tag, "_probe_inval"}, 64'(o_inval), 64'(uniq));
      check({tag, "_probe_latency"}, 64'(o_probe_t), 64'd2);
      check({tag, "_probe_stable"}, 64'(o_unstable), 64'd0);
    end else begin
      check({tag, "_we_latency"}, 64'(o_we_t), 64'd2);
      check({tag, "_grant_latency"}, 64'(o_g_t), 64'd3);
    end
    check({tag, "_update_after_acks"}, 64'(o_early), 64'd0);
    check({tag, "_we_count"}, 64'(o_we_cnt), 64'd1);
    check({tag, "_wr_entry"}, 64'(o_wr), 64'(xw));
    check({tag, "_wr_set"}, 64'(o_wr_set), 64'(set));
    check({tag, "_wr_way"}, 64'(o_wr_way), 64'(way));
    check({tag, "_grant_core"}, 64'(o_gcore), 64'(core));
    check({tag, "_grant_unique"}, 64'(o_gu), 64'(xgu));
    check({tag, "_grant_dirty"}, 64'(o_gd), 64'(xgd));
    check({tag, "_grant_stable"}, 64'(o_gunstable), 64'd0);
  endtask

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    entry_t     e, xw;
    logic [3:0] xm, ad;
    logic       xgu, xgd, u;
    logic [1:0] core;
    logic [7:0] set;
    logic [3:0] way;
    int         guard, we_before;

    vecs[0] = '{mk(0, 4'b0000, 0, 0, 0), 8'd10,  4'd5,  2'd1, 1'b1, 4'b0000, 0, 0, 0, 0,
                4'b0000, mk(1, 4'b0000, 1, 1, 0), 1'b1, 1'b0};
    vecs[1] = '{mk(1, 4'b1010, 0, 0, 0), 8'd20,  4'd2,  2'd1, 1'b1, 4'b0000, 0, 0, 0, 0,
                4'b1000, mk(1, 4'b0000, 1, 1, 0), 1'b1, 1'b0};
    vecs[2] = '{mk(1, 4'b0000, 1, 2, 1), 8'd33,  4'd7,  2'd0, 1'b0, 4'b0100, 0, 0, 0, 0,
                4'b0100, mk(1, 4'b0101, 0, 0, 0), 1'b0, 1'b1};
    vecs[3] = '{mk(1, 4'b1110, 0, 0, 0), 8'd200, 4'd15, 2'd0, 1'b1, 4'b0000, 5, 0, 1, 0,
                4'b1110, mk(1, 4'b0000, 1, 0, 0), 1'b1, 1'b0};
    vecs[4] = '{mk(1, 4'b0011, 0, 0, 0), 8'd255, 4'd0,  2'd2, 1'b0, 4'b0000, 0, 4, 0, 1,
                4'b0000, mk(1, 4'b0111, 0, 0, 0), 1'b0, 1'b0};
    vecs[5] = '{mk(1, 4'b0000, 1, 3, 1), 8'd1,   4'd9,  2'd3, 1'b0, 4'b0000, 0, 0, 0, 0,
                4'b0000, mk(1, 4'b0000, 1, 3, 1), 1'b1, 1'b1};
    vecs[6] = '{mk(1, 4'b0000, 1, 0, 1), 8'd128, 4'd12, 2'd2, 1'b1, 4'b0000, 1, 1, 0, 0,
                4'b0001, mk(1, 4'b0000, 1, 2, 1), 1'b1, 1'b1};
    vecs[7] = '{mk(1, 4'b1000, 0, 0, 0), 8'd64,  4'd3,  2'd2, 1'b1, 4'b1000, 2, 2, 0, 0,
                4'b1000, mk(1, 4'b0000, 1, 2, 1), 1'b1, 1'b1};

    // Power-on reset
    #1 rst_n = 1'b0;
    #1 check("reset_outputs_zero", all_outs, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_low_before_first_clock", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready_o), 64'd1);
    check("idle_not_busy", 64'(busy_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].ent, vecs[i].set, vecs[i].way, vecs[i].core, vecs[i].uniq, vecs[i].adirty,
             vecs[i].rdly, vecs[i].gdly, vecs[i].stray, vecs[i].poke);
      check_txn($sformatf("vec%0d", i), vecs[i].set, vecs[i].way, vecs[i].core, vecs[i].uniq,
                vecs[i].x_mask, vecs[i].x_wr, vecs[i].x_gu, vecs[i].x_gd);
    end

    // Reset while waiting for acks: transaction is dropped without a directory write
    e = mk(1, 4'b0110, 0, 0, 0);
    present_dir(e, 4'd3);
    guard = 0;
    while (!req_ready_o && guard < 20) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_set = 8'd7; req_way = 4'd3; req_core = 2'd0; req_unique = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!probe_valid_o && guard < 20) begin @(negedge clk); guard++; end
    check("abort_probe_seen", 64'(probe_valid_o), 64'd1);
    probe_ready = 1'b1;
    @(negedge clk);
    probe_ready = 1'b0;
    check("abort_in_wait_ack_busy", 64'(busy_o), 64'd1);
    we_before = we_total;
    rst_n = 1'b0;
    #1 check("abort_outputs_zero", all_outs, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_no_dir_write", 64'(we_total), 64'(we_before));
    rst_n = 1'b1;
    #1 check("abort_ready_low_before_clock", 64'(req_ready_o), 64'd0);
    @(negedge clk);
    check("abort_ready_after_release", 64'(req_ready_o), 64'd1);
    model(e, 2'd0, 1'b1, 4'b0010, xm, xw, xgu, xgd);
    do_txn(e, 8'd7, 4'd3, 2'd0, 1'b1, 4'b0010, 0, 0, 0, 0);
    check_txn("after_abort", 8'd7, 4'd3, 2'd0, 1'b1, xm, xw, xgu, xgd);

    // Randomized transactions against the reference model
    for (int i = 0; i < 40; i++) begin
      e = '0;
      if ($urandom_range(0, 3) != 0) begin
        e.v = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          e.ov = 1'b1; e.oid = 2'($urandom_range(0, 3)); e.d = 1'($urandom_range(0, 1));
        end else begin
          e.s = 4'($urandom_range(0, 15));
        end
      end
      core = 2'($urandom_range(0, 3));
      u    = 1'($urandom_range(0, 1));
      ad   = 4'($urandom_range(0, 15));
      set  = 8'($urandom_range(0, 255));
      way  = 4'($urandom_range(0, 15));
      model(e, core, u, ad, xm, xw, xgu, xgd);
      do_txn(e, set, way, core, u, ad, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'b0);
      check_txn($sformatf("rnd%0d", i), set, way, core, u, xm, xw, xgu, xgd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
